// File: rtl/icache_line_fill.sv
// -----------------------------------------------------------------------------
// icache_line_fill
//
// Memory-side responder for the instruction cache miss path. A miss request
// carrying the PC is accepted in IDLE. The aligned line it falls in is then
// read from a word-wide instruction memory one word at a time, and the words
// are assembled into a single wide line for the cache to load.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         synchronous reset, active high
//   req_valid   miss request from the cache
//   req_addr    missing PC; the in-line offset bits are ignored
//   req_ready   high only while idle; request taken on valid && ready
//   mem_rd      word read strobe, held until mem_ack
//   mem_addr    byte address of the word being read (line base + k*word bytes)
//   mem_rdata   read data, sampled in the cycle mem_ack is high
//   mem_ack     read complete; ignored while mem_rd is low
//   line_valid  one-cycle pulse: line_data / line_addr hold a fresh line
//   line_data   word0 in the most significant slot, last word in the least
//   line_addr   base byte address of the line in line_data
//   line_err    one-cycle pulse: fill abandoned because memory never acked
// -----------------------------------------------------------------------------
module icache_line_fill #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             req_ready,
  output logic                             mem_rd,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ack,
  output logic                             line_valid,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] line_data,
  output logic [ADDR_WIDTH-1:0]            line_addr,
  output logic                             line_err
);

  localparam int LINE_WIDTH  = WORD_WIDTH * LINE_WORDS;
  localparam int WORD_BYTES  = WORD_WIDTH / 8;
  localparam int WORD_SHIFT  = $clog2(WORD_BYTES);
  localparam int LINE_OFFSET = $clog2(WORD_BYTES * LINE_WORDS);
  localparam int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CNT_W       = $clog2(TIMEOUT + 1);

  // Clears the byte-within-line bits of a request address.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LINE_OFFSET) - ADDR_WIDTH'(1));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   base_reg,  base_next;
  logic [IDX_W-1:0]        idx_reg,   idx_next;
  logic [CNT_W-1:0]        cnt_reg,   cnt_next;
  logic [LINE_WIDTH-1:0]   line_data_reg;
  logic [ADDR_WIDTH-1:0]   line_addr_reg;

  logic [LINE_WORDS-1:0]   slot_we;     // one-hot: slot written this cycle
  logic                    commit;      // last word arriving, publish line
  logic [ADDR_WIDTH-1:0]   word_off;
  logic [LINE_WIDTH-1:0]   line_fill;   // line as it will look after this cycle

  assign word_off = ADDR_WIDTH'(idx_reg) << WORD_SHIFT;

  // ---------------------------------------------------------------------------
  // Line buffer: one register per word slot. line_fill forwards the word that
  // is being written this cycle, so the last word can be published together
  // with the stored ones without an extra cycle.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
      logic [WORD_WIDTH-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (slot_we[gi]) begin
          word_reg <= mem_rdata;
        end
      end

      // Word 0 lands in the most significant slot of the line.
      assign line_fill[LINE_WIDTH-1-gi*WORD_WIDTH -: WORD_WIDTH] =
        slot_we[gi] ? mem_rdata : word_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      line_data_reg <= '0;
      line_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      // The published line changes only when a complete fill lands, so a
      // timed-out or reset fill never disturbs the previous line.
      if (commit) begin
        line_data_reg <= line_fill;
        line_addr_reg <= base_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    slot_we    = '0;
    commit     = 1'b0;
    req_ready  = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    line_valid = 1'b0;
    line_err   = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          base_next  = req_addr & LINE_MASK;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = FETCH;
        end
      end

      FETCH: begin
        if (cnt_reg == CNT_LIMIT) begin
          // Memory stalled for the full budget on this word: drop the read,
          // flag the abort and discard the partial line.
          line_err   = 1'b1;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          mem_rd   = 1'b1;
          // Base is line aligned and the offset stays inside the line, so
          // this add can never carry into the next line; any wrap past the
          // top of the address space is plain modulo arithmetic.
          mem_addr = base_reg + word_off;
          if (mem_ack) begin
            slot_we[idx_reg] = 1'b1;
            cnt_next         = '0;
            if (idx_reg == LAST_IDX) begin
              commit     = 1'b1;
              state_next = DONE;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      DONE: begin
        line_valid = 1'b1;
        idx_next   = '0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign line_data = line_data_reg;
  assign line_addr = line_addr_reg;

endmodule

// File: tb/tb_icache_line_fill.sv
// -----------------------------------------------------------------------------
// tb_icache_line_fill
//
// Scoreboard bench for icache_line_fill. The stimulus side issues miss
// requests and, at acceptance, pushes the expected outcome (line contents
// read from a behavioural memory, the expected word-address sequence, the
// expected pulse latency) into queues. A monitor process pops and compares
// whenever the DUT pulses line_valid / line_err or completes a word read.
// -----------------------------------------------------------------------------
module tb_icache_line_fill;

  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_ack;
  logic         line_valid;
  logic [127:0] line_data;
  logic [31:0]  line_addr;
  logic         line_err;

  always #5 clk = ~clk;

  icache_line_fill #(
    .ADDR_WIDTH(32),
    .WORD_WIDTH(32),
    .LINE_WORDS(4),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .line_valid(line_valid),
    .line_data (line_data),
    .line_addr (line_addr),
    .line_err  (line_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural instruction memory ----------------
  logic        use_a0      = 1'b0;
  logic [31:0] seed        = 32'h0;
  int          wait_cycles = 0;
  logic        resp_en     = 1'b1;
  logic        force_ack   = 1'b0;
  int          stall_cnt   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic a0,
                                           input logic [31:0] s);
    if (a0) return 32'hA0 + {30'b0, a[3:2]};
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign mem_rdata = mem_word(mem_addr, use_a0, seed);
  assign mem_ack   = force_ack | (mem_rd & resp_en & (stall_cnt >= wait_cycles));

  always @(posedge clk) begin
    if (mem_rd && !mem_ack) stall_cnt <= stall_cnt + 1;
    else                    stall_cnt <= 0;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit           is_err;
    logic [31:0]  addr;
    logic [127:0] data;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [31:0]  addr_q[$];
  logic [127:0] last_data = '0;
  logic [31:0]  last_addr = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (line_valid || line_err) begin
        chk("pulse_exclusive", line_valid & line_err, 1'b0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse (cycle %0d)",
                   line_valid, line_err, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("line @%0d addr=%0h err=%0b", cyc, e.addr, e.is_err);
          chk("pulse_kind_err", line_err, e.is_err);
          chk("pulse_latency", cyc - e.acc, e.lat);
          if (!e.is_err) begin
            chk("line_addr", line_addr, e.addr);
            chk("line_data", line_data, e.data);
            last_data = e.data;
            last_addr = e.addr;
          end else begin
            chk("err_line_data_kept", line_data, last_data);
            chk("err_line_addr_kept", line_addr, last_addr);
            chk("err_mem_rd_low", mem_rd, 1'b0);
          end
        end
      end
      if (mem_rd && mem_ack) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_read: got mem_addr=%0h expected no read", mem_addr);
        end else begin
          ea = addr_q.pop_front();
          chk("mem_addr", mem_addr, ea);
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [31:0] a, input int w, input bit is_err,
                       input bit push_line, input int nacks, input bit hold,
                       output int acc);
    exp_t        e;
    logic [31:0] base;
    base        = a & 32'hFFFF_FFF0;
    wait_cycles = w;
    req_addr    = a;
    req_valid   = 1'b1;
    acc         = -1;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_%0h: got no req_ready expected acceptance", a);
    end else begin
      for (int k = 0; k < nacks; k++) addr_q.push_back(base + 32'(4 * k));
      if (push_line) begin
        e.is_err = is_err;
        e.addr   = base;
        e.acc    = acc;
        e.lat    = is_err ? TIMEOUT + 1 : 1 + 4 * (w + 1);
        e.data   = '0;
        for (int k = 0; k < 4; k++)
          e.data[127-32*k -: 32] = mem_word(base + 32'(4 * k), use_a0, seed);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_idle: got busy after 400 cycles expected idle", name);
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          acc;
    int          acc1;
    int          acc2;
    logic [31:0] ra;
    int          rw;
    bit          seen;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_line_err", line_err, 1'b0);
    chk("rst_line_data", line_data, 128'h0);
    chk("rst_line_addr", line_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait memory, known word values
    use_a0 = 1'b1;
    issue(32'h0000_1234, 0, 1'b0, 1'b1, 4, 1'b0, acc);
    wait_idle("zero_wait");
    chk("t1_line_data", line_data, 128'h000000A0_000000A1_000000A2_000000A3);
    use_a0 = 1'b0;

    // 2: three cycles per word
    seed = 32'h1357_9BDF;
    issue(32'h0000_2008, 2, 1'b0, 1'b1, 4, 1'b0, acc);
    wait_idle("wait_states");

    // 3: memory never answers
    resp_en = 1'b0;
    issue(32'h0000_3004, 0, 1'b1, 1'b1, 0, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (line_err) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      @(negedge clk);
      chk("t3_ready_after_err", req_ready, 1'b1);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL t3_timeout: got no line_err expected pulse");
    end
    resp_en = 1'b1;
    wait_idle("timeout");

    // 4: reset in the middle of a fill, after the second word
    seed = 32'h2468_ACE0;
    issue(32'h0000_0884, 0, 1'b0, 1'b0, 2, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_req_ready", req_ready, 1'b1);
    chk("t4_mem_rd", mem_rd, 1'b0);
    chk("t4_mem_addr", mem_addr, 32'h0);
    chk("t4_line_data", line_data, 128'h0);
    chk("t4_line_addr", line_addr, 32'h0);
    chk("t4_reads_drained", addr_q.size(), 0);
    last_data = '0;
    last_addr = '0;
    rst = 1'b0;
    @(negedge clk);
    issue(32'h0000_0040, 0, 1'b0, 1'b1, 4, 1'b0, acc);
    wait_idle("after_reset");

    // 5: ack stuck high (spurious in IDLE/DONE) and request held across two PCs
    force_ack = 1'b1;
    seed      = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      chk("t5_idle_ready", req_ready, 1'b1);
      chk("t5_idle_mem_rd", mem_rd, 1'b0);
    end
    issue(32'h0000_0100, 0, 1'b0, 1'b1, 4, 1'b1, acc1);
    issue(32'h0000_0200, 0, 1'b0, 1'b1, 4, 1'b0, acc2);
    chk("t5_b2b_gap", acc2 - acc1, 6);
    wait_idle("back_to_back");
    force_ack = 1'b0;

    // 6: top of the address space
    seed = 32'h0BAD_BEEF;
    issue(32'hFFFF_FFF8, 1, 1'b0, 1'b1, 4, 1'b0, acc);
    wait_idle("wrap");

    // Random fills
    for (int t = 0; t < 24; t++) begin
      seed = $urandom;
      ra   = $urandom;
      rw   = int'($urandom_range(0, 4));
      issue(ra, rw, 1'b0, 1'b1, 4, 1'b0, acc);
      wait_idle("random");
    end

    repeat (5) @(negedge clk);
    chk("final_lines_drained", exp_q.size(), 0);
    chk("final_reads_drained", addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
